// File: rtl/fft_serializer.sv
// fft_serializer: parallel-to-serial output stage of the full-parallel FFT.
// Accepts one packed N = 2^NPOINT lane complex frame over a valid/busy
// handshake, then streams it out one sample per transfer, in natural or
// bit-reversed lane order, with sample index and last markers.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   din_valid / din_busy    input frame handshake
//   din_real / din_imag     packed lanes, lane i at [i*WIDTH +: WIDTH]
//   dout_valid / dout_busy  output sample handshake
//   dout_real / dout_imag   current sample
//   dout_index              position k of the sample in the stream
//   dout_last               high with sample k = N-1

// One frame-buffer lane: captures a complex sample when load is high.
// Contents are don't-care after reset, so no reset is applied.
module fft_serializer_lane #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             load,
    input  logic [WIDTH-1:0] d_real,
    input  logic [WIDTH-1:0] d_imag,
    output logic [WIDTH-1:0] q_real,
    output logic [WIDTH-1:0] q_imag
);
    always_ff @(posedge clk) begin
        if (load) begin
            q_real <= d_real;
            q_imag <= d_imag;
        end
    end
endmodule

module fft_serializer #(
    parameter int WIDTH  = 16,
    parameter int NPOINT = 3,
    parameter int BITREV = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din_valid,
    output logic                        din_busy,
    input  logic [WIDTH*(1<<NPOINT)-1:0] din_real,
    input  logic [WIDTH*(1<<NPOINT)-1:0] din_imag,
    output logic                        dout_valid,
    input  logic                        dout_busy,
    output logic [WIDTH-1:0]            dout_real,
    output logic [WIDTH-1:0]            dout_imag,
    output logic [NPOINT-1:0]           dout_index,
    output logic                        dout_last
);
    localparam int N = 1 << NPOINT;
    localparam logic [NPOINT-1:0] K_MAX = NPOINT'(N - 1);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state, state_nxt;

    logic [N-1:0][WIDTH-1:0] fb_real, fb_imag;
    logic [NPOINT-1:0]       k, k_inc;
    logic                    in_xfer, out_xfer, k_last;

    // Stream position k maps to buffer lane k, or to k bit-reversed.
    function automatic logic [NPOINT-1:0] lane_of(input logic [NPOINT-1:0] idx);
        lane_of = idx;
        if (BITREV != 0)
            for (int b = 0; b < NPOINT; b++) lane_of[b] = idx[NPOINT-1-b];
    endfunction

    assign in_xfer  = (state == IDLE) && din_valid;
    assign out_xfer = (state == SEND) && !dout_busy;
    assign k_last   = (k == K_MAX);
    assign k_inc    = k + NPOINT'(1);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_lane
            fft_serializer_lane #(.WIDTH(WIDTH)) u_lane (
                .clk    (clk),
                .load   (in_xfer),
                .d_real (din_real[i*WIDTH +: WIDTH]),
                .d_imag (din_imag[i*WIDTH +: WIDTH]),
                .q_real (fb_real[i]),
                .q_imag (fb_imag[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_xfer) state_nxt = SEND;
            SEND:    if (out_xfer && k_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state / next sample so that no
    // input reaches an output combinationally. Lane L(0) is lane 0 in both
    // orders, so the first sample comes straight from the input bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k          <= '0;
            din_busy   <= 1'b0;
            dout_valid <= 1'b0;
            dout_real  <= '0;
            dout_imag  <= '0;
            dout_last  <= 1'b0;
        end else begin
            din_busy   <= (state_nxt == SEND);
            dout_valid <= (state_nxt == SEND);
            if (in_xfer) begin
                k         <= '0;
                dout_real <= din_real[WIDTH-1:0];
                dout_imag <= din_imag[WIDTH-1:0];
                dout_last <= 1'b0;
            end else if (out_xfer) begin
                if (!k_last) begin
                    k         <= k_inc;
                    dout_real <= fb_real[lane_of(k_inc)];
                    dout_imag <= fb_imag[lane_of(k_inc)];
                    dout_last <= (k_inc == K_MAX);
                end else begin
                    dout_last <= 1'b0;
                end
            end
        end
    end

    assign dout_index = k;
endmodule
